// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_pkg                                                   |
// | Purpose  : Opcode constants, FSM state encoding and a helper         |
// |            shared by the sequential ALU and its combinational core.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_sll  = 4'd5;
    localparam logic [3:0] c_op_srl  = 4'd6;
    localparam logic [3:0] c_op_sra  = 4'd7;
    localparam logic [3:0] c_op_slt  = 4'd8;
    localparam logic [3:0] c_op_sltu = 4'd9;

    // Explicitly encoded 2-bit state register of the sequencer.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True for the three opcodes that iterate one bit per cycle.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == c_op_sll) || (op == c_op_srl) || (op == c_op_sra);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_logic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_logic                                                 |
// | Purpose  : Combinational single-cycle ALU operations. Shift opcodes  |
// |            pass operand A through, which is the zero-amount result.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_logic
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] y
);

    // Opcode decode; unused codes produce zero.
    always_comb begin
        y = '0;
        case (op)
            c_op_add:  y = a + b;
            c_op_sub:  y = a - b;
            c_op_and:  y = a & b;
            c_op_or:   y = a | b;
            c_op_xor:  y = a ^ b;
            c_op_sll,
            c_op_srl,
            c_op_sra:  y = a;
            c_op_slt:  y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            c_op_sltu: y = {{(N-1){1'b0}}, (a < b)};
            default:   y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_seq                                                   |
// | Purpose  : Valid/ready ALU with a one-entry result register. Shifts  |
// |            advance one bit position per cycle; all other ops finish  |
// |            on the accept edge.                                       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero
);

    localparam int c_sh_w = $clog2(N);

    state_t              r_state_q,  w_state_d;
    logic [N-1:0]        r_work_q,   w_work_d;
    logic [N-1:0]        r_result_q, w_result_d;
    logic [c_sh_w-1:0]   r_cnt_q,    w_cnt_d;
    logic [3:0]          r_shop_q,   w_shop_d;
    logic                r_zero_q,   w_zero_d;

    logic [N-1:0]        w_alu_y;
    logic [N-1:0]        w_step;
    logic [c_sh_w-1:0]   w_amt;

    assign w_amt = b[c_sh_w-1:0];

    alu_logic #(
        .N (N)
    ) u_alu_logic (
        .a  (a),
        .b  (b),
        .op (op),
        .y  (w_alu_y)
    );

    // One-bit shift of the working value in the direction of the captured op.
    always_comb begin
        w_step = r_work_q >> 1;
        case (r_shop_q)
            c_op_sll: w_step = r_work_q << 1;
            c_op_sra: w_step = {r_work_q[N-1], r_work_q[N-1:1]};
            default:  w_step = r_work_q >> 1;
        endcase
    end

    // Next-state logic: accept in IDLE, iterate in SHIFT, hold until consumed in DONE.
    always_comb begin
        w_state_d  = r_state_q;
        w_work_d   = r_work_q;
        w_result_d = r_result_q;
        w_cnt_d    = r_cnt_q;
        w_shop_d   = r_shop_q;
        w_zero_d   = r_zero_q;
        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_shop_d = op;
                    if (is_shift(op) && (w_amt != '0)) begin
                        w_state_d = ST_SHIFT;
                        w_work_d  = a;
                        w_cnt_d   = w_amt;
                    end else begin
                        w_state_d  = ST_DONE;
                        w_result_d = w_alu_y;
                        w_zero_d   = (w_alu_y == '0);
                    end
                end
            end
            ST_SHIFT: begin
                w_work_d = w_step;
                w_cnt_d  = r_cnt_q - 1'b1;
                // Last step lands the value straight in the result register.
                if (r_cnt_q == c_sh_w'(1)) begin
                    w_state_d  = ST_DONE;
                    w_result_d = w_step;
                    w_zero_d   = (w_step == '0);
                end
            end
            ST_DONE: begin
                // Result is zeroed on consumption so it reads 0 while not valid.
                if (out_ready) begin
                    w_state_d  = ST_IDLE;
                    w_result_d = '0;
                    w_zero_d   = 1'b0;
                end
            end
            default: begin
                w_state_d  = ST_IDLE;
                w_result_d = '0;
                w_zero_d   = 1'b0;
                w_cnt_d    = '0;
            end
        endcase
    end

    // State registers with synchronous reset discarding any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_work_q   <= '0;
            r_result_q <= '0;
            r_cnt_q    <= '0;
            r_shop_q   <= '0;
            r_zero_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_work_q   <= w_work_d;
            r_result_q <= w_result_d;
            r_cnt_q    <= w_cnt_d;
            r_shop_q   <= w_shop_d;
            r_zero_q   <= w_zero_d;
        end
    end

    assign in_ready  = (r_state_q == ST_IDLE);
    assign out_valid = (r_state_q == ST_DONE);
    assign result    = r_result_q;
    assign zero      = r_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_alu_seq                                                |
// | Purpose  : Directed and randomized self-checking bench for alu_seq   |
// |            against an arithmetic reference model.                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_alu_seq;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;

    int n_total = 0;
    int n_pass  = 0;

    alu_seq #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference result computed directly from the opcode definitions.
    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        int unsigned amt;
        logic signed [31:0] sx;
        amt = y % 32;
        sx  = x;
        case (o)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return x ^ y;
            4'd5:    return x << amt;
            4'd6:    return x >> amt;
            4'd7:    return sx >>> amt;
            4'd8:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd9:    return (x < y) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Cycles from the accept cycle until out_valid is first seen.
    function automatic int latency(input logic [3:0] o, input logic [31:0] y);
        if ((o >= 4'd5) && (o <= 4'd7) && ((y % 32) != 0))
            return int'(y % 32) + 1;
        return 1;
    endfunction

    // Issue one op, scramble inputs while busy, stall for 'hold' cycles, then consume.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int hold);
        logic [31:0] exp;
        int          lat;
        int          cyc;
        exp = model(o, x, y);
        lat = latency(o, y);
        chk({tag, " idle_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        op        = o;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        op       = 4'($urandom);
        cyc      = 1;
        while (!out_valid && cyc < 100) begin
            chk({tag, " busy_result"}, result, 32'd0);
            chk({tag, " busy_ready"}, {31'd0, in_ready}, 32'd0);
            in_valid = 1'($urandom);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " result"}, result, exp);
        chk({tag, " zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
        chk({tag, " done_ready"}, {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            a = $urandom;
            tick();
            chk({tag, " hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, " hold_result"}, result, exp);
            chk({tag, " hold_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, " consumed_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " consumed_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, " consumed_result"}, result, 32'd0);
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", {31'd0, zero}, 32'd0);

        run_op("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op("and", 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
        run_op("sub_zero", 4'd1, 32'd5, 32'd5, 0);
        run_op("sra4", 4'd7, 32'h8000_0000, 32'd4, 0);
        run_op("sll0", 4'd5, 32'd1, 32'd0, 0);
        run_op("backpressure", 4'd4, 32'hDEAD_BEEF, 32'h1234_5678, 3);
        run_op("op15", 4'd15, 32'h0000_1234, 32'h0000_5678, 0);
        run_op("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sll31", 4'd5, 32'hFFFF_FFFF, 32'd31, 1);
        run_op("sra_amt_bits", 4'd7, 32'h4000_0001, 32'hFFFF_FFE1, 0);

        // Reset in the middle of a long shift discards it.
        in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'd31; op = 4'd6;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        chk("rst_shift out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_shift in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_shift result", result, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid || (result != 32'd0)) seen = 1'b1;
        end
        chk("rst_shift no_stale", {31'd0, seen}, 32'd0);

        // Reset wins over out_ready and in_valid while a result waits.
        in_valid = 1'b1; a = 32'd3; b = 32'd4; op = 4'd0;
        tick();
        in_valid = 1'b0;
        chk("rst_done pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk("rst_done out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_done in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_done result", result, 32'd0);
        tick();
        chk("rst_done stays_idle", {31'd0, in_ready}, 32'd1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = 32'd0;
            if (i % 7 == 0) ra = rb;
            run_op("random", ro, ra, rb, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
